// File: rtl/apb_pkg.sv
// ============================================================================
// Module      : apb_pkg
// Description : Shared types and constants for the APB arbiter/master and the
//               counter slave it drives. Holds the master FSM state type, the
//               number of requesters and the default bus widths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package apb_pkg;

    // Requesters sharing the single peripheral bus
    localparam int NUM_REQ = 2;

    // Default bus widths, shared with the counter slave
    localparam int C_APB_ADDR_W = 32;
    localparam int C_APB_DATA_W = 32;

    // Master transfer sequencing
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

endpackage : apb_pkg

`default_nettype wire

// File: rtl/apb_arbiter_master_if.sv
// ============================================================================
// Module      : apb_arbiter_master_if
// Description : Bundles the requester handshake and the peripheral bus of the
//               APB arbiter/master.
//   Requester side : req_valid/req_write/req_addr/req_wdata in,
//                    req_accept/rsp_valid/rsp_rdata/rsp_err out
//   Peripheral side: PSEL/PENABLE/PWRITE/PRWADDR/PRWDATA out,
//                    PRWDATA1/PREADY in
//   Modports       : master (the arbiter/master), slave (its environment)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface apb_arbiter_master_if #(
    parameter int ADDR_W = apb_pkg::C_APB_ADDR_W,
    parameter int DATA_W = apb_pkg::C_APB_DATA_W
) ();

    // Requester handshake; requester i occupies slice [i*W +: W]
    logic [apb_pkg::NUM_REQ-1:0]        req_valid;
    logic [apb_pkg::NUM_REQ-1:0]        req_write;
    logic [apb_pkg::NUM_REQ*ADDR_W-1:0] req_addr;
    logic [apb_pkg::NUM_REQ*DATA_W-1:0] req_wdata;
    logic [apb_pkg::NUM_REQ-1:0]        req_accept;
    logic [apb_pkg::NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]                  rsp_rdata;
    logic                               rsp_err;

    // Peripheral bus
    logic                               PSEL;
    logic                               PENABLE;
    logic                               PWRITE;
    logic [ADDR_W-1:0]                  PRWADDR;
    logic [DATA_W-1:0]                  PRWDATA;
    logic [DATA_W-1:0]                  PRWDATA1;
    logic                               PREADY;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, PRWDATA1, PREADY,
        output req_accept, rsp_valid, rsp_rdata, rsp_err,
               PSEL, PENABLE, PWRITE, PRWADDR, PRWDATA
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, PRWDATA1, PREADY,
        input  req_accept, rsp_valid, rsp_rdata, rsp_err,
               PSEL, PENABLE, PWRITE, PRWADDR, PRWDATA
    );

endinterface : apb_arbiter_master_if

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin grant selection. Remembers the requester
//               served last and prefers the other one when both are valid.
//   PCLK        in  clock, rising edge
//   PRESETn     in  asynchronous active-low reset
//   i_req_valid in  per-requester request
//   i_adv       in  strobe: a transfer finished, record i_adv_idx as last
//   i_adv_idx   in  index of the requester whose transfer finished
//   o_gnt_any   out at least one requester is valid
//   o_gnt_idx   out index that would be granted this cycle
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter2
    import apb_pkg::*;
(
    input  logic               PCLK,
    input  logic               PRESETn,
    input  logic [NUM_REQ-1:0] i_req_valid,
    input  logic               i_adv,
    input  logic               i_adv_idx,
    output logic               o_gnt_any,
    output logic               o_gnt_idx
);

    logic r_last;   // requester served most recently
    logic w_pref;   // requester favoured this cycle

    // Reset value 1 makes requester 0 the favoured one out of reset
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_last <= 1'b1;
        end else if (i_adv) begin
            r_last <= i_adv_idx;
        end
    end

    assign w_pref    = ~r_last;
    assign o_gnt_any = |i_req_valid;
    assign o_gnt_idx = i_req_valid[w_pref] ? w_pref : ~w_pref;

endmodule : rr_arbiter2

`default_nettype wire

// File: rtl/apb_arbiter_master.sv
// ============================================================================
// Module      : apb_arbiter_master
// Description : Round-robin arbiter plus APB-style master. Grants one of two
//               requesters, runs the SETUP and ACCESS phases on the shared
//               peripheral bus and returns read data or a timeout error.
//   PCLK     in  clock, rising edge
//   PRESETn  in  asynchronous active-low reset
//   bus      --  apb_arbiter_master_if.master (requester handshake and
//                peripheral bus, all outputs registered)
//   TIMEOUT  parameter: ACCESS cycles without PREADY before the transfer is
//            aborted with rsp_err; must be >= 2
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_arbiter_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = C_APB_ADDR_W,
    parameter int DATA_W  = C_APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESETn,
    apb_arbiter_master_if.master bus
);

    localparam int                 C_CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(TIMEOUT - 1);

    // FSM and output registers
    state_t               r_state;
    logic [C_CNT_W-1:0]   r_cnt;
    logic                 r_gnt;
    logic                 r_psel;
    logic                 r_penable;
    logic                 r_pwrite;
    logic [ADDR_W-1:0]    r_paddr;
    logic [DATA_W-1:0]    r_pwdata;
    logic [NUM_REQ-1:0]   r_accept;
    logic [NUM_REQ-1:0]   r_rsp_valid;
    logic [DATA_W-1:0]    r_rsp_rdata;
    logic                 r_rsp_err;

    // Next-state values
    state_t               w_state_nxt;
    logic [C_CNT_W-1:0]   w_cnt_nxt;
    logic                 w_psel_nxt;
    logic                 w_penable_nxt;
    logic [NUM_REQ-1:0]   w_accept_nxt;
    logic [NUM_REQ-1:0]   w_rsp_valid_nxt;
    logic [DATA_W-1:0]    w_rsp_rdata_nxt;
    logic                 w_rsp_err_nxt;
    logic                 w_load;       // capture granted requester's fields
    logic                 w_done;       // transfer finishes at this edge

    // Arbitration
    logic                 w_gnt_any;
    logic                 w_gnt_idx;

    rr_arbiter2 u_arb (
        .PCLK        (PCLK),
        .PRESETn     (PRESETn),
        .i_req_valid (bus.req_valid),
        .i_adv       (w_done),
        .i_adv_idx   (r_gnt),
        .o_gnt_any   (w_gnt_any),
        .o_gnt_idx   (w_gnt_idx)
    );

    // ------------------------------------------------------------------
    // Next state and next registered outputs. Outputs are registered, so
    // each branch describes what the bus shows during the following cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_psel_nxt      = 1'b0;
        w_penable_nxt   = 1'b0;
        w_accept_nxt    = '0;
        w_rsp_valid_nxt = '0;
        w_rsp_rdata_nxt = '0;
        w_rsp_err_nxt   = 1'b0;
        w_load          = 1'b0;
        w_done          = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_gnt_any) begin
                    w_state_nxt  = SETUP;
                    w_psel_nxt   = 1'b1;
                    w_accept_nxt = w_gnt_idx ? 2'b10 : 2'b01;
                    w_load       = 1'b1;
                end
            end

            SETUP: begin
                w_state_nxt   = ACCESS;
                w_psel_nxt    = 1'b1;
                w_penable_nxt = 1'b1;
                w_cnt_nxt     = '0;
            end

            ACCESS: begin
                // PREADY wins over a timeout hitting in the same cycle
                if (bus.PREADY) begin
                    w_state_nxt     = IDLE;
                    w_done          = 1'b1;
                    w_rsp_valid_nxt = r_gnt ? 2'b10 : 2'b01;
                    w_rsp_rdata_nxt = r_pwrite ? '0 : bus.PRWDATA1;
                end else if (r_cnt == C_CNT_LAST) begin
                    w_state_nxt     = IDLE;
                    w_done          = 1'b1;
                    w_rsp_valid_nxt = r_gnt ? 2'b10 : 2'b01;
                    w_rsp_err_nxt   = 1'b1;
                end else begin
                    w_psel_nxt    = 1'b1;
                    w_penable_nxt = 1'b1;
                    w_cnt_nxt     = r_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers. Asynchronous reset drops PSEL/PENABLE
    // and all pulses at once; an interrupted transfer never responds.
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_accept    <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_psel      <= w_psel_nxt;
            r_penable   <= w_penable_nxt;
            r_accept    <= w_accept_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_rdata <= w_rsp_rdata_nxt;
            r_rsp_err   <= w_rsp_err_nxt;
        end
    end

    // Transfer fields: only the granted requester is sampled, and the
    // values hold between transfers.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_gnt    <= 1'b0;
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
        end else if (w_load) begin
            r_gnt    <= w_gnt_idx;
            r_pwrite <= bus.req_write[w_gnt_idx];
            r_paddr  <= w_gnt_idx ? bus.req_addr[2*ADDR_W-1:ADDR_W]
                                  : bus.req_addr[ADDR_W-1:0];
            r_pwdata <= w_gnt_idx ? bus.req_wdata[2*DATA_W-1:DATA_W]
                                  : bus.req_wdata[DATA_W-1:0];
        end
    end

    assign bus.PSEL       = r_psel;
    assign bus.PENABLE    = r_penable;
    assign bus.PWRITE     = r_pwrite;
    assign bus.PRWADDR    = r_paddr;
    assign bus.PRWDATA    = r_pwdata;
    assign bus.req_accept = r_accept;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_rdata  = r_rsp_rdata;
    assign bus.rsp_err    = r_rsp_err;

endmodule : apb_arbiter_master

`default_nettype wire

// File: tb/tb_apb_arbiter_master.sv
// ============================================================================
// Module      : tb_apb_arbiter_master
// Description : Self-checking bench for apb_arbiter_master: directed vector
//               table, hand-written corner sequences and randomized traffic
//               checked cycle by cycle against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_arbiter_master;
    import apb_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    localparam int SLV_REG  = 0;   // registered PREADY, like the counter slave
    localparam int SLV_ZERO = 1;   // PREADY stuck low
    localparam int SLV_RAND = 2;   // random PREADY every cycle
    localparam int SLV_MAN  = 3;   // PREADY driven directly by the sequence

    logic PCLK    = 1'b0;
    logic PRESETn = 1'b0;
    always #5 PCLK = ~PCLK;

    apb_arbiter_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    apb_arbiter_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .bus     (bus)
    );

    // ---------------- peripheral model ----------------
    int          slv_mode  = SLV_REG;
    logic        man_ready = 1'b0;
    logic        rd_ovr    = 1'b0;
    logic [31:0] rd_val    = 32'h0;
    logic        pready_r;

    always @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) pready_r <= 1'b0;
        else begin
            case (slv_mode)
                SLV_REG:  pready_r <= bus.PSEL && bus.PENABLE && !pready_r;
                SLV_RAND: pready_r <= ($urandom_range(0, 3) == 0);
                default:  pready_r <= 1'b0;
            endcase
        end
    end

    assign bus.PREADY   = (slv_mode == SLV_MAN) ? man_ready : pready_r;
    assign bus.PRWDATA1 = rd_ovr ? rd_val : (bus.PRWADDR ^ 32'hC0DE_0000);

    // ---------------- checking helpers ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Transfer rules: a grant happens at an edge where no transfer is open and
    // some request is valid, favouring the requester not served last. Then one
    // SETUP cycle, then ACCESS cycles until PREADY or until TO cycles elapsed,
    // then a one-cycle response to the granted requester.
    logic [1:0]  e_acc, e_rsp;
    logic        e_err, e_psel, e_pen;
    logic [31:0] e_rdata;
    logic        m_busy, m_g, m_last, m_w;
    int          m_nacc;
    logic [31:0] m_addr, m_wdata;

    initial begin
        logic pref, g;
        forever begin
            @(negedge PCLK);
            if (!PRESETn) begin
                e_acc = 2'b00; e_rsp = 2'b00; e_err = 1'b0; e_rdata = 32'h0;
                e_psel = 1'b0; e_pen = 1'b0;
                m_busy = 1'b0; m_last = 1'b1; m_g = 1'b0; m_nacc = 0;
                m_w = 1'b0; m_addr = 32'h0; m_wdata = 32'h0;
                chk("rst_psel",    64'(bus.PSEL),       64'(0));
                chk("rst_penable", 64'(bus.PENABLE),    64'(0));
                chk("rst_accept",  64'(bus.req_accept), 64'(0));
                chk("rst_rsp",     64'(bus.rsp_valid),  64'(0));
            end else begin
                chk("mon_accept",  64'(bus.req_accept), 64'(e_acc));
                chk("mon_rsp",     64'(bus.rsp_valid),  64'(e_rsp));
                chk("mon_psel",    64'(bus.PSEL),       64'(e_psel));
                chk("mon_penable", 64'(bus.PENABLE),    64'(e_pen));
                if (e_rsp != 2'b00) begin
                    chk("mon_rdata", 64'(bus.rsp_rdata), 64'(e_rdata));
                    chk("mon_err",   64'(bus.rsp_err),   64'(e_err));
                end
                chk("mon_pwrite", 64'(bus.PWRITE),  64'(m_w));
                chk("mon_paddr",  64'(bus.PRWADDR), 64'(m_addr));
                chk("mon_pwdata", 64'(bus.PRWDATA), 64'(m_wdata));

                e_acc = 2'b00; e_rsp = 2'b00; e_err = 1'b0; e_rdata = 32'h0;
                e_psel = 1'b0; e_pen = 1'b0;
                if (!m_busy) begin
                    if (bus.req_valid != 2'b00) begin
                        pref    = ~m_last;
                        g       = bus.req_valid[pref] ? pref : ~pref;
                        m_g     = g;
                        m_w     = bus.req_write[g];
                        m_addr  = g ? bus.req_addr[63:32]  : bus.req_addr[31:0];
                        m_wdata = g ? bus.req_wdata[63:32] : bus.req_wdata[31:0];
                        m_busy  = 1'b1;
                        m_nacc  = 0;
                        e_acc[g] = 1'b1;
                        e_psel   = 1'b1;
                    end
                end else if (m_nacc == 0) begin
                    m_nacc = 1; e_psel = 1'b1; e_pen = 1'b1;
                end else if (bus.PREADY || m_nacc == TO) begin
                    e_rsp[m_g] = 1'b1;
                    e_err      = !bus.PREADY;
                    e_rdata    = (bus.PREADY && !m_w) ? bus.PRWDATA1 : 32'h0;
                    m_last     = m_g;
                    m_busy     = 1'b0;
                end else begin
                    m_nacc++; e_psel = 1'b1; e_pen = 1'b1;
                end
            end
        end
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        int          slv;
        logic        rq;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdv;
        logic [1:0]  exp_rsp;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_sel;
        int          exp_en;
    } vec_t;

    vec_t vecs[6];

    task automatic set_req(input logic rq, input logic wr, input logic [31:0] a, input logic [31:0] d);
        bus.req_valid[rq] = 1'b1;
        bus.req_write[rq] = wr;
        if (rq) begin bus.req_addr[63:32] = a; bus.req_wdata[63:32] = d; end
        else    begin bus.req_addr[31:0]  = a; bus.req_wdata[31:0]  = d; end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int nsel = 0, nen = 0, nacc = 0, nrsp = 0;
        logic [1:0]  rsp = 2'b00;
        logic [31:0] rd = 32'h0;
        logic        er = 1'b0, fields_ok = 1'b1, done = 1'b0;
        slv_mode = v.slv; rd_ovr = 1'b1; rd_val = v.rdv;
        set_req(v.rq, v.wr, v.addr, v.wdata);
        for (int c = 0; c < 60 && !done; c++) begin
            @(posedge PCLK); #1;
            if (bus.req_accept != 2'b00) begin
                nacc++;
                if (bus.req_accept[v.rq]) bus.req_valid[v.rq] = 1'b0;
            end
            if (bus.PSEL) begin
                nsel++;
                if (bus.PRWADDR !== v.addr || bus.PWRITE !== v.wr) fields_ok = 1'b0;
                if (v.wr && bus.PRWDATA !== v.wdata) fields_ok = 1'b0;
            end
            if (bus.PENABLE) nen++;
            if (bus.rsp_valid != 2'b00) begin
                nrsp++; rsp = bus.rsp_valid; rd = bus.rsp_rdata; er = bus.rsp_err; done = 1'b1;
            end
        end
        @(posedge PCLK); #1;
        if (bus.rsp_valid != 2'b00) nrsp++;
        chk($sformatf("vec%0d_rsp", idx),    64'(rsp),       64'(v.exp_rsp));
        chk($sformatf("vec%0d_rdata", idx),  64'(rd),        64'(v.exp_rdata));
        chk($sformatf("vec%0d_err", idx),    64'(er),        64'(v.exp_err));
        chk($sformatf("vec%0d_nsel", idx),   64'(nsel),      64'(v.exp_sel));
        chk($sformatf("vec%0d_nen", idx),    64'(nen),       64'(v.exp_en));
        chk($sformatf("vec%0d_nacc", idx),   64'(nacc),      64'(1));
        chk($sformatf("vec%0d_nrsp", idx),   64'(nrsp),      64'(1));
        chk($sformatf("vec%0d_fields", idx), 64'(fields_ok), 64'(1));
    endtask

    task automatic do_reset();
        @(posedge PCLK); #1;
        PRESETn = 1'b0;
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1'b1;
    endtask

    // Clear each valid once accepted, for a fixed number of cycles
    task automatic drain(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(posedge PCLK); #1;
            bus.req_valid = bus.req_valid & ~bus.req_accept;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int nen, nrsp, ngr, gap_low;
        logic [1:0]  order [4];
        logic [1:0]  first_acc;
        logic [31:0] rd;

        vecs[0] = '{SLV_REG,  1'b0, 1'b1, 32'h4,         32'h5,         32'h0,         2'b01, 32'h0,         1'b0, 3,  2};
        vecs[1] = '{SLV_REG,  1'b1, 1'b0, 32'h4,         32'h0,         32'h7,         2'b10, 32'h7,         1'b0, 3,  2};
        vecs[2] = '{SLV_ZERO, 1'b0, 1'b0, 32'h10,        32'h0,         32'h1234,      2'b01, 32'h0,         1'b1, 17, 16};
        vecs[3] = '{SLV_REG,  1'b0, 1'b0, 32'h8,         32'h0,         32'hCAFE_F00D, 2'b01, 32'hCAFE_F00D, 1'b0, 3,  2};
        vecs[4] = '{SLV_REG,  1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h0,         2'b10, 32'h0,         1'b0, 3,  2};
        vecs[5] = '{SLV_ZERO, 1'b1, 1'b1, 32'h20,        32'hAA,        32'h99,        2'b10, 32'h0,         1'b1, 17, 16};

        bus.req_valid = 2'b00; bus.req_write = 2'b00;
        bus.req_addr  = '0;    bus.req_wdata = '0;
        repeat (3) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        @(posedge PCLK); #1;

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // ---- spurious PREADY in IDLE/SETUP, then 3 wait states ----
        slv_mode = SLV_MAN; man_ready = 1'b1; rd_ovr = 1'b1; rd_val = 32'h55;
        set_req(1'b0, 1'b0, 32'h30, 32'h0);
        nen = 0; nrsp = 0; rd = 32'h0;
        for (int c = 0; c < 30; c++) begin
            @(posedge PCLK); #1;
            bus.req_valid = bus.req_valid & ~bus.req_accept;
            if (bus.rsp_valid != 2'b00) begin nrsp++; rd = bus.rsp_rdata; end
            if (bus.PENABLE) begin nen++; man_ready = (nen >= 4); end
        end
        man_ready = 1'b0;
        chk("spur_nen",   64'(nen),  64'(4));
        chk("spur_nrsp",  64'(nrsp), 64'(1));
        chk("spur_rdata", 64'(rd),   64'(32'h55));

        // ---- contention from reset: grant order 0,1,0,1 ----
        slv_mode = SLV_REG; rd_ovr = 1'b0;
        do_reset();
        set_req(1'b0, 1'b1, 32'h100, 32'h11);
        set_req(1'b1, 1'b0, 32'h200, 32'h22);
        ngr = 0; gap_low = 0;
        for (int c = 0; c < 100 && ngr < 4; c++) begin
            @(posedge PCLK); #1;
            if (!bus.PSEL) gap_low = 1;
            if (bus.req_accept != 2'b00) begin
                order[ngr] = bus.req_accept;
                if (ngr > 0) chk($sformatf("cont_gap%0d", ngr), 64'(gap_low), 64'(1));
                gap_low = 0;
                ngr++;
                set_req(1'b0, 1'b1, 32'h100 + 32'(ngr), $urandom);
                set_req(1'b1, 1'b0, 32'h200 + 32'(ngr), $urandom);
            end
        end
        chk("cont_ngrants", 64'(ngr), 64'(4));
        if (ngr == 4) begin
            chk("cont_order0", 64'(order[0]), 64'(2'b01));
            chk("cont_order1", 64'(order[1]), 64'(2'b10));
            chk("cont_order2", 64'(order[2]), 64'(2'b01));
            chk("cont_order3", 64'(order[3]), 64'(2'b10));
        end
        bus.req_valid = 2'b00;
        repeat (20) @(posedge PCLK);
        #1;

        // ---- reset in the first ACCESS cycle ----
        set_req(1'b1, 1'b0, 32'h44, 32'h0);
        nen = 0;
        for (int c = 0; c < 10 && nen == 0; c++) begin
            @(posedge PCLK); #1;
            bus.req_valid = bus.req_valid & ~bus.req_accept;
            if (bus.PENABLE) nen = 1;
        end
        chk("rstmid_reached_access", 64'(nen), 64'(1));
        #2 PRESETn = 1'b0;
        #1;
        chk("rstmid_psel",    64'(bus.PSEL),    64'(0));
        chk("rstmid_penable", 64'(bus.PENABLE), 64'(0));
        nrsp = 0;
        repeat (2) begin
            @(posedge PCLK); #1;
            if (bus.rsp_valid != 2'b00) nrsp++;
        end
        PRESETn = 1'b1;
        set_req(1'b0, 1'b0, 32'h50, 32'h0);
        set_req(1'b1, 1'b0, 32'h54, 32'h0);
        first_acc = 2'b00;
        for (int c = 0; c < 10 && first_acc == 2'b00; c++) begin
            @(posedge PCLK); #1;
            if (bus.rsp_valid != 2'b00) nrsp++;
            first_acc = bus.req_accept;
            bus.req_valid = bus.req_valid & ~bus.req_accept;
        end
        chk("rstmid_no_rsp",    64'(nrsp),      64'(0));
        chk("rstmid_first_gnt", 64'(first_acc), 64'(2'b01));
        drain(40);

        // ---- randomized traffic with random wait states and resets ----
        slv_mode = SLV_RAND; rd_ovr = 1'b0;
        for (int c = 1; c <= 3000; c++) begin
            @(posedge PCLK); #1;
            if (c % 997 == 0) PRESETn = 1'b0;
            else if (c % 997 == 2) PRESETn = 1'b1;
            for (int i = 0; i < 2; i++) begin
                if (bus.req_valid[i] && bus.req_accept[i]) begin
                    if ($urandom_range(0, 1) == 0) bus.req_valid[i] = 1'b0;
                    else set_req(1'(i), 1'($urandom_range(0, 1)), $urandom, $urandom);
                end else if (!bus.req_valid[i] && $urandom_range(0, 3) == 0) begin
                    set_req(1'(i), 1'($urandom_range(0, 1)), $urandom, $urandom);
                end
            end
        end
        PRESETn = 1'b1;
        bus.req_valid = 2'b00;
        repeat (30) @(posedge PCLK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_apb_arbiter_master

`default_nettype wire
